// File: rtl/pe_tx_queue_pkg.sv
// Packet layout shared by pe, the Hoplite switch and pe_tx_queue:
// {addrx, addry, data}, MSB first, plus field slice macros and MYPOS.
`ifndef PE_TX_QUEUE_PKG_SV
`define PE_TX_QUEUE_PKG_SV

`define PKT_ADDR(p, pw, xaw, yaw)  p[(pw)-1 -: ((xaw)+(yaw))]
`define PKT_ADDRX(p, pw, xaw)      p[(pw)-1 -: (xaw)]
`define PKT_ADDRY(p, pw, xaw, yaw) p[(pw)-(xaw)-1 -: (yaw)]
`define PKT_DATA(p, pw, xaw, yaw)  p[(pw)-(xaw)-(yaw)-1 : 0]
`define MYPOS(xp, yp, xaw, yaw)    {(xaw)'(xp), (yaw)'(yp)}

package pe_tx_queue_pkg;
  localparam int P_W_DEF  = 16;
  localparam int X_AW_DEF = 2;
  localparam int Y_AW_DEF = 2;

  // Pointer width for a buffer of d entries; a single-entry buffer still needs one bit.
  function automatic int ptr_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction
endpackage

`endif

// File: rtl/sync_fifo_mem.sv
// Circular packet buffer of D entries; pointers wrap modulo D, which need not
// be a power of two. Occupancy is tracked by the owner.
module sync_fifo_mem
  import pe_tx_queue_pkg::*;
#(
  parameter int W = 16,
  parameter int D = 7
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o
);
  localparam int PW = ptr_w(D);
  localparam logic [PW-1:0] LAST = PW'(D - 1);

  logic [W-1:0]  mem_q [D];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_i) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
    if (rd_en_i) rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
endmodule

// File: rtl/pe_tx_queue.sv
// Elastic PE-to-switch injection queue: (DEPTH-1)-entry buffer plus output register.
// Define PE_TX_STATS_EN to add tx_cnt/stall_cnt counters.
module pe_tx_queue
  import pe_tx_queue_pkg::*;
#(
  parameter int P_W   = P_W_DEF,
  parameter int X_AW  = X_AW_DEF,
  parameter int Y_AW  = Y_AW_DEF,
  parameter int X_POS = 0,
  parameter int Y_POS = 0,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [P_W-1:0]         pe_pkt,
  input  logic                   pe_vld,
  output logic                   pe_rdy,
  output logic [P_W-1:0]         out_pkt,
  output logic                   out_vld,
  input  logic                   sw_rdy,
  output logic [$clog2(DEPTH):0] level
`ifdef PE_TX_STATS_EN
  ,
  output logic [31:0]            tx_cnt,
  output logic [31:0]            stall_cnt
`endif
);
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int MEM_D = DEPTH - 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pe_tx_queue: DEPTH must be a power of 2 and at least 2");
  end
  if (X_POS < 0 || X_POS >= (1 << X_AW) || Y_POS < 0 || Y_POS >= (1 << Y_AW)) begin : g_bad_pos
    $error("pe_tx_queue: MYPOS does not fit the torus address widths");
  end

  logic [LVL_W-1:0] level_q, level_d;
  logic [P_W-1:0]   out_pkt_q, out_pkt_d;
  logic             out_vld_q, out_vld_d;
  logic             pe_rdy_q, pe_rdy_d;
  logic [P_W-1:0]   rd_data;
  logic             push, pop, buf_empty, out_free, wr_en, rd_en;

  // Handshakes: a transfer happens at an edge where valid and ready are both high.
  assign push      = pe_vld && pe_rdy_q;
  assign pop       = out_vld_q && sw_rdy;
  assign buf_empty = (level_q == {{(LVL_W-1){1'b0}}, out_vld_q});
  assign out_free  = !out_vld_q || pop;
  assign rd_en     = out_free && !buf_empty;
  assign wr_en     = push && !(out_free && buf_empty);

  always_comb begin
    out_vld_d = out_vld_q;
    out_pkt_d = out_pkt_q;
    level_d   = level_q;
    if (out_free) begin
      if (!buf_empty) begin
        out_vld_d = 1'b1;
        out_pkt_d = rd_data;
      end else if (push) begin
        out_vld_d = 1'b1;
        out_pkt_d = pe_pkt;
      end else begin
        out_vld_d = 1'b0;
      end
    end
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (!push && pop) level_d = level_q - LVL_W'(1);
    // Ready is derived from the next level so sw_rdy never reaches pe_rdy combinationally.
    pe_rdy_d = (level_d < LVL_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      level_q   <= '0;
      out_pkt_q <= '0;
      out_vld_q <= 1'b0;
      pe_rdy_q  <= 1'b0;
    end else begin
      level_q   <= level_d;
      out_pkt_q <= out_pkt_d;
      out_vld_q <= out_vld_d;
      pe_rdy_q  <= pe_rdy_d;
    end
  end

  sync_fifo_mem #(.W(P_W), .D(MEM_D)) u_mem (
    .clk_i     (clk),
    .rst_n_i   (rst),
    .wr_en_i   (wr_en),
    .wr_data_i (pe_pkt),
    .rd_en_i   (rd_en),
    .rd_data_o (rd_data)
  );

  assign pe_rdy  = pe_rdy_q;
  assign out_pkt = out_pkt_q;
  assign out_vld = out_vld_q;
  assign level   = level_q;

`ifdef PE_TX_STATS_EN
  logic [31:0] tx_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pop)                  tx_cnt_q    <= tx_cnt_q + 32'd1;
      if (out_vld_q && !sw_rdy) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign tx_cnt    = tx_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_pe_tx_queue.sv
// Directed bench for pe_tx_queue: accepted packets feed an expected queue that a
// monitor drains on every switch handshake; directed checks cover level/ready timing.
module tb_pe_tx_queue;
  localparam int P_W   = 16;
  localparam int DEPTH = 8;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [P_W-1:0]   pe_pkt;
  logic             pe_vld;
  logic             pe_rdy;
  logic [P_W-1:0]   out_pkt;
  logic             out_vld;
  logic             sw_rdy;
  logic [LVL_W-1:0] level;
`ifdef PE_TX_STATS_EN
  logic [31:0]      tx_cnt;
  logic [31:0]      stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  logic [P_W-1:0] exp_q[$];

  pe_tx_queue #(.P_W(P_W), .X_AW(2), .Y_AW(2), .X_POS(1), .Y_POS(2), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .pe_pkt  (pe_pkt),
    .pe_vld  (pe_vld),
    .pe_rdy  (pe_rdy),
    .out_pkt (out_pkt),
    .out_vld (out_vld),
    .sw_rdy  (sw_rdy),
    .level   (level)
`ifdef PE_TX_STATS_EN
    ,
    .tx_cnt    (tx_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver: inputs change 1 time unit after the rising edge; outputs are checked there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Record every packet the queue will accept at the coming edge.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
    end else if (pe_vld && pe_rdy) begin
      exp_q.push_back(pe_pkt);
      n_acc++;
    end
  end

  // Monitor: every switch handshake must retire the oldest accepted packet.
  always @(negedge clk) begin
    if (rst && out_vld && sw_rdy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h expected no packet", out_pkt);
      end else begin
        check("pop_order", {16'h0, out_pkt}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst    = 1'b0;
    pe_vld = 1'b1;
    pe_pkt = 16'h5555;
    sw_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_out_vld", {31'h0, out_vld}, 32'd0);
      check("rst_out_pkt", {16'h0, out_pkt}, 32'd0);
      check("rst_level",   {28'h0, level},   32'd0);
      check("rst_pe_rdy",  {31'h0, pe_rdy},  32'd0);
    end
    rst    = 1'b1;
    pe_vld = 1'b0;
    step();
    check("rdy_after_rst", {31'h0, pe_rdy}, 32'd1);

    // Latency and order
    pe_vld = 1'b1;
    pe_pkt = 16'h1001;
    step();
    check("lat_vld", {31'h0, out_vld}, 32'd1);
    check("lat_pkt", {16'h0, out_pkt}, 32'h1001);
    pe_pkt = 16'h2002;
    step();
    check("seq_pkt2", {16'h0, out_pkt}, 32'h2002);
    pe_pkt = 16'h3003;
    step();
    check("seq_pkt3", {16'h0, out_pkt}, 32'h3003);
    pe_vld = 1'b0;
    step();
    check("seq_drain_vld", {31'h0, out_vld}, 32'd0);
    check("seq_level",     {28'h0, level},   32'd0);

    // Back-pressure hold
    sw_rdy = 1'b0;
    pe_vld = 1'b1;
    pe_pkt = 16'hABCD;
    step();
    pe_vld = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("hold_vld", {31'h0, out_vld}, 32'd1);
      check("hold_pkt", {16'h0, out_pkt}, 32'hABCD);
      if (i < 9) step();
    end
    sw_rdy = 1'b1;
    step();
    check("hold_popped", {31'h0, out_vld}, 32'd0);
    check("hold_level",  {28'h0, level},   32'd0);

    // Full
    sw_rdy = 1'b0;
    pe_vld = 1'b1;
    n_acc  = 0;
    for (int i = 0; i < 10; i++) begin
      pe_pkt = 16'hF000 + 16'(i);
      step();
    end
    check("full_accepted", n_acc, 32'd8);
    check("full_level",    {28'h0, level},  32'd8);
    check("full_rdy",      {31'h0, pe_rdy}, 32'd0);
    pe_pkt = 16'hF0A0;
    sw_rdy = 1'b1;
    step();
    sw_rdy = 1'b0;
    check("full_pop_rdy",   {31'h0, pe_rdy}, 32'd1);
    check("full_pop_level", {28'h0, level},  32'd7);
    step();
    check("full_9th_level", {28'h0, level},  32'd8);
    check("full_9th_rdy",   {31'h0, pe_rdy}, 32'd0);
    pe_vld = 1'b0;
    sw_rdy = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("pp_start_level", {28'h0, level}, 32'd4);

    // Simultaneous push and pop across pointer wrap
    pe_vld = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pe_pkt = 16'h7000 + 16'(i);
      step();
      check("pp_level", {28'h0, level}, 32'd4);
    end

    // Mid-operation reset at level 5
    sw_rdy = 1'b0;
    pe_pkt = 16'h8888;
    step();
    check("mid_level5", {28'h0, level}, 32'd5);
    rst    = 1'b0;
    pe_vld = 1'b0;
    step();
    check("mid_rst_level",   {28'h0, level},   32'd0);
    check("mid_rst_out_vld", {31'h0, out_vld}, 32'd0);
    check("mid_rst_out_pkt", {16'h0, out_pkt}, 32'd0);
    check("mid_rst_pe_rdy",  {31'h0, pe_rdy},  32'd0);
`ifdef PE_TX_STATS_EN
    check("mid_rst_tx_cnt",    tx_cnt,    32'd0);
    check("mid_rst_stall_cnt", stall_cnt, 32'd0);
`endif
    rst = 1'b1;
    step();
    check("mid_rdy_after_rst", {31'h0, pe_rdy}, 32'd1);

    // One packet stalled for three edges, then popped
    pe_vld = 1'b1;
    pe_pkt = 16'h1234;
    step();
    pe_vld = 1'b0;
    check("stall_pkt",   {16'h0, out_pkt}, 32'h1234);
    check("stall_level", {28'h0, level},   32'd1);
    for (int i = 0; i < 3; i++) step();
`ifdef PE_TX_STATS_EN
    check("stall_cnt3", stall_cnt, 32'd3);
`endif
    sw_rdy = 1'b1;
    step();
    check("stall_popped", {31'h0, out_vld}, 32'd0);
    check("stall_level0", {28'h0, level},   32'd0);
`ifdef PE_TX_STATS_EN
    check("tx_cnt1",      tx_cnt,    32'd1);
    check("stall_cnt_end", stall_cnt, 32'd3);
`endif
    sw_rdy = 1'b0;
    step();
    check("sb_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
